// File: rtl/jtpang_objdma.sv
// Object DMA: on a CPU strobe, takes the Z80 bus and copies LEN bytes from
// shared RAM (starting at SRC) into the object buffer, three cen cycles
// per byte (address, read, write).
module jtpang_objdma #(
  parameter int              AW     = 12,
  parameter int              LEN    = 512,
  parameter logic [AW-1:0]   SRC    = '0,
  parameter bit              VBWAIT = 1'b1,
  localparam int             OW     = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          LVBL,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic [AW-1:0] dma_addr,
  output logic          dma_cs,
  input  logic [7:0]    ram_dout,
  output logic [OW-1:0] obj_addr,
  output logic [7:0]    obj_din,
  output logic          obj_we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAITVB = 3'd1,
    ST_REQ    = 3'd2,
    ST_ADDR   = 3'd3,
    ST_READ   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_REL    = 3'd6
  } state_t;

  localparam logic [OW-1:0] LAST_BYTE = OW'(LEN - 1);

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic          go_prev_q;
  logic [OW-1:0] cnt_q, cnt_d;       // byte counter, also the object-buffer address
  logic [AW-1:0] off_q, off_d;       // source offset from SRC, wraps modulo 2**AW
  logic [7:0]    din_q, din_d;

  logic go_edge;
  logic granted;
  logic in_xfer;

  // Rising-edge detect on the CPU strobe, evaluated every clk (not cen-gated)
  assign go_edge = dma_go & ~go_prev_q;
  assign granted = cen & ~busak_n;
  assign in_xfer = (state_q == ST_ADDR) || (state_q == ST_READ) || (state_q == ST_WRITE);

  // Next-state, counters and captured data; bus loss freezes the byte loop in place
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | go_edge;
    cnt_d     = cnt_q;
    off_d     = off_q;
    din_d     = din_q;
    case (state_q)
      ST_IDLE: begin
        if (cen && pending_d) begin
          state_d   = VBWAIT ? ST_WAITVB : ST_REQ;
          pending_d = 1'b0;
        end
      end
      ST_WAITVB: begin
        if (cen && !LVBL) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (granted) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
          off_d   = '0;
        end
      end
      ST_ADDR: begin
        if (granted) state_d = ST_READ;
      end
      ST_READ: begin
        if (granted) begin
          din_d   = ram_dout;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (granted) begin
          cnt_d   = cnt_q + 1'b1;
          off_d   = off_q + 1'b1;
          state_d = (cnt_q == LAST_BYTE) ? ST_REL : ST_ADDR;
        end
      end
      ST_REL: begin
        if (cen) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over cen and drops the bus at once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      go_prev_q <= 1'b0;
      cnt_q     <= '0;
      off_q     <= '0;
      din_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      go_prev_q <= dma_go;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      din_q     <= din_d;
    end
  end

  // Outputs decoded from state; bus-side strobes are masked whenever the grant drops
  always_comb begin
    busrq_n  = ~((state_q == ST_REQ) || in_xfer);
    dma_cs   = in_xfer & ~busak_n;
    obj_we   = (state_q == ST_WRITE) & granted;
    busy     = (state_q != ST_IDLE) && (state_q != ST_REL);
    done     = (state_q == ST_REL) & cen;
    dma_addr = SRC + off_q;
    obj_addr = cnt_q;
    obj_din  = din_q;
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: one instance with VBWAIT=0 and a source
// window that wraps past the top of RAM, one with VBWAIT=1.
module tb_jtpang_objdma;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic cen;
  always #5 clk = ~clk;

  // Instance A: SRC=0xFFE, LEN=4, VBWAIT=0
  logic          rst_n_a, go_a, lvbl_a, busak_a;
  logic          busrq_n_a, dma_cs_a, obj_we_a, busy_a, done_a;
  logic [AW-1:0] dma_addr_a;
  logic [7:0]    ram_a, obj_din_a;
  logic [1:0]    obj_addr_a;

  // Instance B: SRC=0x010, LEN=4, VBWAIT=1
  logic          rst_n_b, go_b, lvbl_b, busak_b;
  logic          busrq_n_b, dma_cs_b, obj_we_b, busy_b, done_b;
  logic [AW-1:0] dma_addr_b;
  logic [7:0]    ram_b, obj_din_b;
  logic [1:0]    obj_addr_b;

  jtpang_objdma #(.AW(AW), .LEN(4), .SRC(12'hFFE), .VBWAIT(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .cen(cen), .dma_go(go_a), .LVBL(lvbl_a),
    .busrq_n(busrq_n_a), .busak_n(busak_a), .dma_addr(dma_addr_a), .dma_cs(dma_cs_a),
    .ram_dout(ram_a), .obj_addr(obj_addr_a), .obj_din(obj_din_a), .obj_we(obj_we_a),
    .busy(busy_a), .done(done_a)
  );

  jtpang_objdma #(.AW(AW), .LEN(4), .SRC(12'h010), .VBWAIT(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .cen(cen), .dma_go(go_b), .LVBL(lvbl_b),
    .busrq_n(busrq_n_b), .busak_n(busak_b), .dma_addr(dma_addr_b), .dma_cs(dma_cs_b),
    .ram_dout(ram_b), .obj_addr(obj_addr_b), .obj_din(obj_din_b), .obj_we(obj_we_b),
    .busy(busy_b), .done(done_b)
  );

  // Shared-RAM model: content is address[7:0]^0x5A, one cen cycle of read latency
  always @(posedge clk) begin
    if (cen) begin
      ram_a <= dma_addr_a[7:0] ^ 8'h5A;
      ram_b <= dma_addr_b[7:0] ^ 8'h5A;
    end
  end

  // Write / done logger, sampled on the falling edge
  int            wr_cnt, done_cnt, done_cnt_b;
  logic [AW-1:0] log_src [64];
  logic [1:0]    log_oa  [64];
  logic [7:0]    log_din [64];

  always @(negedge clk) begin
    if (obj_we_a) begin
      if (wr_cnt < 64) begin
        log_src[wr_cnt] = dma_addr_a;
        log_oa[wr_cnt]  = obj_addr_a;
        log_din[wr_cnt] = obj_din_a;
      end
      wr_cnt = wr_cnt + 1;
      $display("write src=%03h obj_addr=%0d din=%02h", dma_addr_a, obj_addr_a, obj_din_a);
    end
    if (done_a) done_cnt = done_cnt + 1;
    if (done_b) done_cnt_b = done_cnt_b + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [1:0]    oa;
    logic [7:0]    din;
  } vec_t;

  vec_t vecs [4];

  task automatic check_log(input int base);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("src[%0d]", base + i), 32'(log_src[base + i]), 32'(vecs[i].src));
      check($sformatf("oa[%0d]", base + i),  32'(log_oa[base + i]),  32'(vecs[i].oa));
      check($sformatf("din[%0d]", base + i), 32'(log_din[base + i]), 32'(vecs[i].din));
    end
  endtask

  task automatic clear_log();
    wr_cnt = 0;
    done_cnt = 0;
    done_cnt_b = 0;
  endtask

  task automatic pulse_go_a();
    @(negedge clk); go_a = 1'b1;
    @(negedge clk); go_a = 1'b0;
  endtask

  task automatic wait_done_a(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_reached_a", 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    int n, gap_we, gap_cs, gap_rq;

    // Hand-computed expected writes for SRC=0xFFE, LEN=4
    vecs[0] = '{src: 12'hFFE, oa: 2'd0, din: 8'hA4};
    vecs[1] = '{src: 12'hFFF, oa: 2'd1, din: 8'hA5};
    vecs[2] = '{src: 12'h000, oa: 2'd2, din: 8'h5A};
    vecs[3] = '{src: 12'h001, oa: 2'd3, din: 8'h5B};

    clear_log();
    cen = 1'b0;
    rst_n_a = 1'b0; go_a = 1'b0; lvbl_a = 1'b1; busak_a = 1'b1;
    rst_n_b = 1'b0; go_b = 1'b0; lvbl_b = 1'b1; busak_b = 1'b1;

    // Reset with cen held low
    repeat (3) @(posedge clk);
    #1;
    check("rst_busrq_n", 32'(busrq_n_a), 32'd1);
    check("rst_dma_cs",  32'(dma_cs_a),  32'd0);
    check("rst_obj_we",  32'(obj_we_a),  32'd0);
    check("rst_busy",    32'(busy_a),    32'd0);
    check("rst_done",    32'(done_a),    32'd0);
    check("rst_obj_din", 32'(obj_din_a), 32'd0);
    check("rst_dma_addr", 32'(dma_addr_a), 32'h0FFE);
    check("rst_obj_addr", 32'(obj_addr_a), 32'd0);
    @(negedge clk);
    cen = 1'b1; rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (2) @(negedge clk);

    // Basic transfer: request follows the strobe, 12 cycles from grant to release
    go_a = 1'b1;
    @(posedge clk); #1;
    check("go_busrq_n", 32'(busrq_n_a), 32'd0);
    check("go_busy",    32'(busy_a),    32'd1);
    @(negedge clk); go_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("wait_ak_busrq_n", 32'(busrq_n_a), 32'd0);
    check("wait_ak_dma_cs",  32'(dma_cs_a),  32'd0);
    @(negedge clk); busak_a = 1'b0;
    @(posedge clk);
    n = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      n++;
      if (busrq_n_a) break;
    end
    check("grant_to_release", 32'(n), 32'd12);
    check("rel_done", 32'(done_a), 32'd1);
    check("rel_busy", 32'(busy_a), 32'd0);
    @(negedge clk); busak_a = 1'b1;
    repeat (4) @(negedge clk);
    check("xfer1_writes", 32'(wr_cnt), 32'd4);
    check("xfer1_dones",  32'(done_cnt), 32'd1);
    check_log(0);

    // Three strobes during a transfer queue exactly one more transfer
    clear_log();
    busak_a = 1'b0;
    pulse_go_a();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      go_a = 1'b1;
      @(negedge clk); go_a = 1'b0;
      @(negedge clk);
    end
    wait_done_a(2, 200);
    repeat (30) @(negedge clk);
    check("queued_dones",  32'(done_cnt), 32'd2);
    check("queued_writes", 32'(wr_cnt),   32'd8);
    check_log(4);

    // Bus taken away for 5 clocks mid-transfer
    clear_log();
    busak_a = 1'b0;
    pulse_go_a();
    repeat (5) @(negedge clk);
    busak_a = 1'b1;
    gap_we = 0; gap_cs = 0; gap_rq = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (obj_we_a)  gap_we++;
      if (dma_cs_a)  gap_cs++;
      if (busrq_n_a) gap_rq++;
    end
    busak_a = 1'b0;
    check("gap_obj_we",  32'(gap_we), 32'd0);
    check("gap_dma_cs",  32'(gap_cs), 32'd0);
    check("gap_busrq_hi", 32'(gap_rq), 32'd0);
    wait_done_a(1, 100);
    repeat (4) @(negedge clk);
    check("gap_writes", 32'(wr_cnt), 32'd4);
    check_log(0);
    busak_a = 1'b1;

    // Reset mid-transfer drops the bus and never signals done
    clear_log();
    busak_a = 1'b0;
    pulse_go_a();
    repeat (3) @(negedge clk);
    rst_n_a = 1'b0;
    @(posedge clk); #1;
    check("midrst_busrq_n", 32'(busrq_n_a), 32'd1);
    check("midrst_busy",    32'(busy_a),    32'd0);
    check("midrst_dma_cs",  32'(dma_cs_a),  32'd0);
    @(negedge clk); rst_n_a = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_done",  32'(done_cnt),  32'd0);
    check("midrst_busrq_hi", 32'(busrq_n_a), 32'd1);
    busak_a = 1'b1;

    // VBWAIT=1: request held off until LVBL falls
    @(negedge clk); go_b = 1'b1;
    @(posedge clk); #1;
    check("vb_busy",    32'(busy_b),    32'd1);
    check("vb_busrq_n", 32'(busrq_n_b), 32'd1);
    @(negedge clk); go_b = 1'b0;
    repeat (4) @(negedge clk);
    check("vb_hold_busrq_n", 32'(busrq_n_b), 32'd1);
    lvbl_b = 1'b0;
    @(posedge clk); #1;
    check("vb_fall_busrq_n", 32'(busrq_n_b), 32'd0);
    @(negedge clk); busak_b = 1'b0;
    n = 0;
    while (done_cnt_b < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("vb_done", 32'(done_cnt_b), 32'd1);
    lvbl_b = 1'b1; busak_b = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtpang_objdma.md
JTPANG_OBJDMA -- requirements
Module: jtpang_objdma

Interface
REQ-001 Parameter AW, default 12, width of the shared-RAM source address.
REQ-002 Parameter LEN, default 512, number of bytes per transfer; 1..2**AW.
REQ-003 Parameter SRC, default 0, first source address, AW bits.
REQ-004 Parameter VBWAIT, default 1; 1 means a transfer may only start while LVBL is low.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 cen  in  1  clock enable; FSM and counters advance only when cen is high.
REQ-008 dma_go  in  1  CPU I/O strobe requesting one object transfer; level, may last several clocks.
REQ-009 LVBL  in  1  vertical blank, active-low.
REQ-010 busrq_n  out  1  Z80 bus request, active-low.
REQ-011 busak_n  in  1  Z80 bus acknowledge, active-low.
REQ-012 dma_addr  out  AW  shared-RAM read address.
REQ-013 dma_cs  out  1  shared-RAM read select, high while the bus is owned.
REQ-014 ram_dout  in  8  shared-RAM data, valid one cen cycle after dma_addr.
REQ-015 obj_addr  out  log2(LEN)  object-buffer write address.
REQ-016 obj_din  out  8  object-buffer write data.
REQ-017 obj_we  out  1  object-buffer write strobe, one clock wide.
REQ-018 busy  out  1  high from request acceptance until bus release.
REQ-019 done  out  1  one-clock pulse when a transfer completes.

Function
REQ-020 dma_go is edge-detected on clk: a low-to-high transition sets a pending flag; a held level sets it only once.
REQ-021 FSM states: IDLE, WAITVB, REQ, ADDR, READ, WRITE, REL.
REQ-022 IDLE: pending set -> WAITVB (VBWAIT=1) or REQ (VBWAIT=0); pending clears on leaving IDLE; busy rises on the same edge.
REQ-023 WAITVB: on a cen cycle with LVBL low -> REQ.
REQ-024 REQ: busrq_n driven low; on a cen cycle with busak_n low -> ADDR with source counter = SRC and byte counter = 0.
REQ-025 ADDR: dma_addr = source counter, dma_cs high; next cen -> READ.
REQ-026 READ: ram_dout registered into obj_din on the cen edge; -> WRITE.
REQ-027 WRITE: obj_we high for exactly one clk, obj_addr = byte counter; counters then increment; byte counter = LEN-1 -> REL, else -> ADDR.
REQ-028 Each byte takes 3 cen cycles; a transfer takes 3*LEN cen cycles after grant.
REQ-029 Source counter wraps modulo 2**AW; SRC+LEN beyond the top continues from address 0.
REQ-030 REL: busrq_n high, dma_cs low, done pulses one clk, busy low -> IDLE on the next cen.
REQ-031 A dma_go edge while busy sets pending; at most one transfer is queued; further edges while pending is set are dropped.
REQ-032 busak_n returning high during ADDR/READ/WRITE: FSM freezes, dma_cs low, obj_we low, counters held; resumes in the same state when busak_n is low again.
REQ-033 dma_go edge and REL on the same clk: pending sets; the new transfer starts from IDLE.
REQ-034 busrq_n stays low from REQ until REL; it never toggles between bytes.

Reset
REQ-035 While rst_n is low at a clk edge: FSM = IDLE, pending = 0, counters = 0, busrq_n = 1, dma_cs = 0, obj_we = 0, busy = 0, done = 0, obj_din = 0, dma_addr = SRC.
REQ-036 Reset during a transfer releases the bus on that edge; the partial transfer is not resumed.
REQ-037 Reset takes effect regardless of cen.

Verification
REQ-038 Using cen=1, LEN=4, VBWAIT=0: dma_go pulse -> busrq_n low next clk; busak_n low -> obj_we at obj_addr 0..3 with obj_din = RAM[SRC..SRC+3]; done once; busrq_n high 12 cycles after grant.
REQ-039 Using VBWAIT=1 and LVBL high: dma_go -> busy high, busrq_n stays high until LVBL falls, then asserts on the next cen.
REQ-040 Using SRC=0xFFE, LEN=4: read addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-041 Three dma_go edges during a transfer -> exactly two transfers, two done pulses.
REQ-042 busak_n high for 5 clks mid-transfer -> no obj_we during the gap, the written byte sequence is unchanged, and the total number of writes = LEN.
REQ-043 rst_n low mid-transfer -> busrq_n = 1 on that edge, and no done pulse follows.
